// File: rtl/gcd_arbiter_if.sv
// Client-side and GCD-side handshake bundle for gcd_arbiter.
// The master modport is the arbiter's view; slave is the clients/GCD-unit view.
interface gcd_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 16
);
  logic [N_REQ-1:0]   cli_req;
  logic [N_REQ*W-1:0] cli_a;
  logic [N_REQ*W-1:0] cli_b;
  logic [N_REQ-1:0]   cli_ack;
  logic [W-1:0]       cli_c;
  logic               gcd_req;
  logic [W-1:0]       gcd_ab;
  logic               gcd_ack;
  logic [W-1:0]       gcd_c;

  modport master (
    input  cli_req, cli_a, cli_b, gcd_ack, gcd_c,
    output cli_ack, cli_c, gcd_req, gcd_ab
  );

  modport slave (
    output cli_req, cli_a, cli_b, gcd_ack, gcd_c,
    input  cli_ack, cli_c, gcd_req, gcd_ab
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one serial-operand GCD unit among N_REQ clients.
// Operands are latched at grant; the result is returned under a four-phase handshake.
module gcd_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  gcd_arbiter_if.master            bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [15:0]              done_cnt
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_REL_A, S_SEND_B, S_REL_B, S_RESP, S_DONE
  } state_e;

  state_e           state_q;
  logic [GW-1:0]    last_q;
  logic [GW-1:0]    grant_q;
  logic [W-1:0]     op_a_q;
  logic [W-1:0]     op_b_q;
  logic [W-1:0]     res_q;
  logic [W-1:0]     gcd_ab_q;
  logic [W-1:0]     cli_c_q;
  logic             gcd_req_q;
  logic             busy_q;
  logic [N_REQ-1:0] cli_ack_q;
  logic [CW-1:0]    done_cnt_q;

  logic [GW-1:0]    win_c;
  logic             found_c;
  int unsigned      idx_c;
  logic [W-1:0]     sel_a_c;
  logic [W-1:0]     sel_b_c;

  // Round-robin winner: scan from last+1 upward, wrapping at N_REQ.
  always_comb begin
    win_c   = '0;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx_c = (32'(last_q) + i) % N_REQ;
      if (!found_c && bus.cli_req[GW'(idx_c)]) begin
        win_c   = GW'(idx_c);
        found_c = 1'b1;
      end
    end
  end

  assign sel_a_c = W'(bus.cli_a >> (32'(win_c) * W));
  assign sel_b_c = W'(bus.cli_b >> (32'(win_c) * W));

  // Sequencer: every output is a register updated on the transition into its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_q     <= GW'(N_REQ - 1);
      grant_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      gcd_ab_q   <= '0;
      cli_c_q    <= '0;
      gcd_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      cli_ack_q  <= '0;
      done_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (found_c) begin
            grant_q   <= win_c;
            op_a_q    <= sel_a_c;
            op_b_q    <= sel_b_c;
            gcd_ab_q  <= sel_a_c;
            gcd_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_SEND_A;
          end
        end
        S_SEND_A: begin
          gcd_ab_q <= op_a_q;
          if (bus.gcd_ack) begin
            gcd_req_q <= 1'b0;
            state_q   <= S_REL_A;
          end
        end
        S_REL_A: begin
          if (!bus.gcd_ack) begin
            gcd_req_q <= 1'b1;
            gcd_ab_q  <= op_b_q;
            state_q   <= S_SEND_B;
          end else begin
            gcd_ab_q  <= op_a_q;
          end
        end
        S_SEND_B: begin
          if (bus.gcd_ack) begin
            res_q     <= bus.gcd_c;
            gcd_req_q <= 1'b0;
            state_q   <= S_REL_B;
          end
        end
        S_REL_B: begin
          if (!bus.gcd_ack) begin
            gcd_ab_q <= '0;
            // A client that dropped its request early forfeits the result.
            if (bus.cli_req[grant_q]) begin
              cli_ack_q <= N_REQ'(1) << grant_q;
              cli_c_q   <= res_q;
              state_q   <= S_RESP;
            end else begin
              last_q  <= grant_q;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        S_RESP: begin
          if (!bus.cli_req[grant_q]) begin
            cli_ack_q <= '0;
            cli_c_q   <= '0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          last_q     <= grant_q;
          done_cnt_q <= done_cnt_q + CW'(1);
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gcd_req = gcd_req_q;
  assign bus.gcd_ab  = gcd_ab_q;
  assign bus.cli_ack = cli_ack_q;
  assign bus.cli_c   = cli_c_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural GCD unit, auto-responding clients
// and a scoreboard of expected (client, result) pairs in service order.
module tb_gcd_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;

  typedef struct {
    int          cli;
    logic [15:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [1:0]  grant_id;
  logic [15:0] done_cnt;

  gcd_arbiter_if #(.N_REQ(N), .W(W)) bus ();

  gcd_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [15:0] ab_log[$];
  int   rereq[N];
  bit   rr_pend[N];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gcd16(logic [15:0] a, logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural GCD unit: two four-phase transfers (A then B), fixed ack latency.
  int          m_phase;
  int          m_cnt;
  logic [15:0] m_a;
  bit          m_dropped;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase     <= 0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_dropped   <= 1'b0;
      bus.gcd_ack <= 1'b0;
      bus.gcd_c   <= '0;
    end else begin
      case (m_phase)
        0, 2: if (bus.gcd_req) begin
          if (m_cnt == LAT) begin
            ab_log.push_back(bus.gcd_ab);
            if (m_phase == 0) m_a <= bus.gcd_ab;
            else              bus.gcd_c <= gcd16(m_a, bus.gcd_ab);
            bus.gcd_ack <= 1'b1;
            m_phase     <= m_phase + 1;
            m_cnt       <= 0;
          end else m_cnt <= m_cnt + 1;
        end
        default: if (!bus.gcd_req) begin
          m_dropped <= 1'b1;
          if (m_cnt == LAT) begin
            bus.gcd_ack <= 1'b0;
            m_dropped   <= 1'b0;
            m_phase     <= (m_phase == 1) ? 2 : 0;
            m_cnt       <= 0;
          end else m_cnt <= m_cnt + 1;
        end
      endcase
    end
  end

  // Once the arbiter has released gcd_req in a REL state it must not re-raise it before ack falls.
  always @(negedge clk) begin
    if (!reset && m_dropped && bus.gcd_ack) check("req_during_rel", 32'(bus.gcd_req), 0);
  end

  // Clients: drop request on ack; optionally re-request one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.cli_ack[i] && bus.cli_req[i]) begin
          bus.cli_req[i] = 1'b0;
          if (rereq[i] > 0) begin
            rereq[i]--;
            rr_pend[i] = 1'b1;
          end
        end else if (rr_pend[i] && !bus.cli_ack[i]) begin
          bus.cli_req[i] = 1'b1;
          rr_pend[i]     = 1'b0;
        end
      end
    end
  end

  // Scoreboard: compare each new ack against the next expected (client, result).
  logic [N-1:0] prev_ack = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (bus.cli_ack != 0 && prev_ack == 0) begin
        int   idx;
        exp_t e;
        idx = 0;
        for (int i = 0; i < N; i++) if (bus.cli_ack[i]) idx = i;
        check("ack_onehot", 32'($onehot(bus.cli_ack)), 1);
        check("ack_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ack_client", 32'(idx), 32'(e.cli));
          check("grant_id", 32'(grant_id), 32'(e.cli));
          check("cli_c", 32'(bus.cli_c), 32'(e.res));
        end
      end else if (bus.cli_ack == 0 && prev_ack == 0 && !reset) begin
        check("cli_c_idle", 32'(bus.cli_c), 0);
      end
      prev_ack = bus.cli_ack;
    end
  end

  task automatic push(int cli, logic [15:0] res);
    exp_t e;
    e.cli = cli;
    e.res = res;
    sb.push_back(e);
  endtask

  task automatic set_ops(int i, logic [15:0] a, logic [15:0] b);
    bus.cli_a[i*W +: W] = a;
    bus.cli_b[i*W +: W] = b;
  endtask

  task automatic start_job(int i, logic [15:0] a, logic [15:0] b);
    set_ops(i, a, b);
    bus.cli_req[i] = 1'b1;
  endtask

  task automatic wait_done(int budget);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_in_time", 32'(sb.size() == 0 && !busy), 1);
  endtask

  task automatic wait_busy(int budget);
    for (int k = 0; k < budget && !busy; k++) @(negedge clk);
    check("granted", 32'(busy), 1);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(string tag);
    check({tag, "_ack"}, 32'(bus.cli_ack), 0);
    check({tag, "_cli_c"}, 32'(bus.cli_c), 0);
    check({tag, "_gcd_req"}, 32'(bus.gcd_req), 0);
    check({tag, "_gcd_ab"}, 32'(bus.gcd_ab), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 0);
  endtask

  initial begin
    bus.cli_req = '0;
    bus.cli_a   = '0;
    bus.cli_b   = '0;
    for (int i = 0; i < N; i++) begin
      rereq[i]   = 0;
      rr_pend[i] = 1'b0;
    end
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single client 0: 12, 18 -> 6
    ab_log.delete();
    push(0, 16'd6);
    start_job(0, 16'd12, 16'd18);
    wait_done(200);
    check("t1_ab_count", 32'(ab_log.size()), 2);
    if (ab_log.size() == 2) begin
      check("t1_ab_a", 32'(ab_log[0]), 12);
      check("t1_ab_b", 32'(ab_log[1]), 18);
    end
    check("t1_done_cnt", 32'(done_cnt), 1);

    // All four clients at once: served 0,1,2,3
    pulse_reset();
    push(0, 16'd12); push(1, 16'd1); push(2, 16'd25); push(3, 16'd9);
    set_ops(0, 16'd48, 16'd36);
    set_ops(1, 16'd7, 16'd5);
    set_ops(2, 16'd100, 16'd75);
    set_ops(3, 16'd9, 16'd9);
    bus.cli_req = 4'hF;
    wait_done(600);
    check("t2_done_cnt", 32'(done_cnt), 4);

    // Fairness: clients 1 and 3 keep re-requesting -> 1,3,1,3,...
    rereq[1] = 3;
    rereq[3] = 3;
    for (int j = 0; j < 4; j++) begin
      push(1, 16'd6);
      push(3, 16'd7);
    end
    set_ops(1, 16'd48, 16'd18);
    set_ops(3, 16'd35, 16'd21);
    bus.cli_req[1] = 1'b1;
    bus.cli_req[3] = 1'b1;
    wait_done(2000);
    check("t3_done_cnt", 32'(done_cnt), 12);

    // Abandoned job on client 2, client 0 served afterwards
    ab_log.delete();
    push(0, 16'd7);
    start_job(2, 16'd30, 16'd45);
    wait_busy(20);
    check("t4_grant2", 32'(grant_id), 2);
    start_job(0, 16'd14, 16'd21);
    for (int k = 0; k < 100 && !(bus.gcd_req && bus.gcd_ab == 16'd45); k++) @(negedge clk);
    check("t4_in_send_b", 32'(bus.gcd_req && bus.gcd_ab == 16'd45), 1);
    bus.cli_req[2] = 1'b0;
    wait_done(400);
    check("t4_done_cnt", 32'(done_cnt), 13);
    check("t4_ab_count", 32'(ab_log.size()), 4);
    if (ab_log.size() == 4) begin
      check("t4_ab0", 32'(ab_log[0]), 30);
      check("t4_ab1", 32'(ab_log[1]), 45);
      check("t4_ab2", 32'(ab_log[2]), 14);
      check("t4_ab3", 32'(ab_log[3]), 21);
    end

    // Operand stability: change cli_a after grant
    push(0, 16'd7);
    start_job(0, 16'd21, 16'd14);
    wait_busy(20);
    bus.cli_a[0 +: W] = 16'd99;
    wait_done(400);
    check("t5_done_cnt", 32'(done_cnt), 14);

    // Reset during REL_A, then a fresh job
    start_job(0, 16'd50, 16'd20);
    for (int k = 0; k < 100 && !(m_phase == 1 && !bus.gcd_req); k++) @(negedge clk);
    check("t6_in_rel_a", 32'(m_phase == 1 && !bus.gcd_req), 1);
    reset = 1'b1;
    bus.cli_req = '0;
    @(negedge clk);
    check_outputs_zero("t6_in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("t6_after_reset");
    push(0, 16'd4);
    start_job(0, 16'd8, 16'd12);
    wait_done(400);
    check("t6_done_cnt", 32'(done_cnt), 1);
    check("t6_sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Round-robin arbiter and sequencer that shares one `gcd` FSMD unit among `N_REQ` client ports. Each client presents both operands in parallel under a four-phase req/ack handshake. The arbiter grants one client, latches its operands and drives the two-phase operand transfer (A, then B) over the GCD unit's serial `AB` port. It then returns the result to the granted client on a shared result bus.

## Interface
- `N_REQ`, default 4: number of client ports (2..8).
- `W`, default 16: operand/result width; must equal the GCD unit width.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cli_req` in N_REQ: per-client request; bit i high = client i has a job.
- `cli_a` in N_REQ*W: client i operand A at bits [i*W +: W].
- `cli_b` in N_REQ*W: client i operand B at bits [i*W +: W].
- `cli_ack` out N_REQ: per-client completion; at most one bit high (one-hot or zero).
- `cli_c` out W: result; valid while any `cli_ack` bit is high, otherwise 0.
- `gcd_req` out 1: request to GCD unit.
- `gcd_ab` out W: operand to GCD unit.
- `gcd_ack` in 1: ack from GCD unit.
- `gcd_c` in W: result from GCD unit, valid with the second `gcd_ack`.
- `busy` out 1: high in every state except IDLE.
- `grant_id` out clog2(N_REQ): index of current or last granted client.
- `done_cnt` out 16: count of results delivered to clients; wraps 0xFFFF -> 0.

## Operation
- The FSM has seven states:
  - IDLE: if any `cli_req` bit is high, select the winner g by round-robin. Search starts at `last+1` mod N_REQ, increasing index, wrapping. Latch `cli_a[g]` -> `op_a` and `cli_b[g]` -> `op_b`, set `grant_id=g`, go to SEND_A.
  - SEND_A: `gcd_req=1`, `gcd_ab=op_a`; on `gcd_ack=1`, go to REL_A.
  - REL_A: `gcd_req=0`, `gcd_ab=op_a`; on `gcd_ack=0`, go to SEND_B.
  - SEND_B: `gcd_req=1`, `gcd_ab=op_b`; on `gcd_ack=1`, capture `gcd_c` -> `res`, go to REL_B.
  - REL_B: `gcd_req=0`; on `gcd_ack=0`, go to RESP if `cli_req[g]` is still high, else go to IDLE (result discarded).
  - RESP: `cli_ack[g]=1`, `cli_c=res`; on `cli_req[g]=0`, go to DONE.
  - DONE: `cli_ack=0`, `last<=g`, `done_cnt<=done_cnt+1`, go to IDLE.
- Pointer update on discard: in the discard path (REL_B -> IDLE), `last<=g` and `done_cnt` is unchanged.
- `gcd_ab` is held stable for the whole time `gcd_req` is high. In IDLE it is 0.
- Operands are latched at grant, so later changes to `cli_a`/`cli_b` have no effect on the active job. Clients must still hold `cli_req` until they see `cli_ack`.
- A client dropping `cli_req` before RESP is a protocol violation. The arbiter still completes the GCD transaction (the GCD unit must return to its idle state), then discards the result.
- Requests from non-granted clients are ignored until the FSM returns to IDLE. They are not lost as long as the clients hold `cli_req`.
- No operand checking is done. A or B = 0 is forwarded unchanged; its behaviour is defined by the GCD unit.

## Timing
- Reset values: state=IDLE, `last=N_REQ-1` (so client 0 has first priority), `op_a`/`op_b`/`res`=0, `grant_id=0`, `done_cnt=0`. All outputs are 0.
- Asserting `reset` in any state aborts the job immediately and drops `gcd_req` and `cli_ack`. The GCD unit shares the same `reset`, so both restart together.
- Grant latency: `cli_req` sampled high in IDLE -> `gcd_req` high on the next cycle.
- Every transition is registered. Each wait state lasts at least 1 cycle, and longer while it waits for its condition.
- Overhead beyond the GCD unit's own latency: the IDLE grant cycle plus the DONE cycle, i.e. 2 cycles per job.
- Re-arbitration: when the granted client releases in RESP and re-requests in the cycle after DONE, it is lowest priority relative to other pending clients.
- Simultaneous requests in the same IDLE cycle: exactly one grant, by the round-robin order above.
- `done_cnt` increments exactly once per completed RESP handshake.

## Test plan
- Single client: client 0 sends A=12, B=18 -> `gcd_ab` is 12 then 18; `cli_ack[0]=1` with `cli_c=6`; `done_cnt=1`; `gcd_req` never high while `gcd_ack` is high in a REL state.
- All four clients request in the same cycle with (48,36), (7,5), (100,75), (9,9) -> served in order 0,1,2,3; results 12, 1, 25, 9; each `cli_ack` is one-hot; `done_cnt=4`.
- Fairness: clients 1 and 3 hold `cli_req` continuously and each re-requests the cycle after DONE -> grants alternate 1,3,1,3 over 8 jobs.
- Abandoned job: client 2 (A=30, B=45) drops `cli_req` during SEND_B -> the GCD transfer completes, no `cli_ack[2]`, `done_cnt` unchanged, next pending client is served normally.
- Operand stability: client 0 changes `cli_a` from 21 to 99 after grant -> result is gcd(21,14)=7.
- Reset mid-op: assert `reset` for 1 cycle during REL_A -> all outputs 0 and `done_cnt=0`; a following request from client 0 (8,12) completes with `cli_c=4`.
